// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of imem_loader.
// A byte moves on a rising clk edge exactly when rx_valid && rx_ready; rx_data must be stable while rx_valid is high, and im_wr_en is a one-cycle write strobe with im_waddr/im_wdata valid in the same cycle.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_wr_en;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, im_wr_en, im_waddr, im_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, im_wr_en, im_waddr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit instruction memory writes and holds the core in reset until the image is complete.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  input  logic         reload,
  output logic         cpu_reset,
  output logic         done,
  output logic         error,
  output logic [2:0]   state_dbg
);
  typedef enum logic [2:0] {
    LEN0 = 3'd0,
    LEN1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [16:0] DEPTH_LIM = 17'(IMEM_DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_IMAGE = CSUM;
  localparam logic   READY_AFTER = 1'b1;
  logic [7:0] csum;
`else
  // Without a checksum the loader stops accepting as soon as the image ends.
  localparam state_t AFTER_IMAGE = DONE;
  localparam logic   READY_AFTER = 1'b0;
`endif

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] word_count;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_buf;
  logic        accept;
  logic [15:0] len_rx;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign len_rx    = {bus.rx_data, len_lo};
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN0;
      bus.rx_ready <= 1'b0;
      bus.im_wr_en <= 1'b0;
      bus.im_waddr <= '0;
      bus.im_wdata <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      len_lo       <= '0;
      word_count   <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      asm_buf      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      bus.im_wr_en <= 1'b0;
      case (state)
        LEN0: begin
          bus.rx_ready <= 1'b1;
          if (accept) begin
            len_lo <= bus.rx_data;
            state  <= LEN1;
          end
        end
        LEN1: begin
          bus.rx_ready <= 1'b1;
          if (accept) begin
            if ({1'b0, len_rx} > DEPTH_LIM) begin
              state        <= ERR;
              error        <= 1'b1;
              bus.rx_ready <= 1'b0;
            end else if (len_rx == 16'd0) begin
              state        <= AFTER_IMAGE;
              bus.rx_ready <= READY_AFTER;
            end else begin
              state      <= DATA;
              word_count <= len_rx;
            end
          end
        end
        DATA: begin
          bus.rx_ready <= 1'b1;
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_buf[7:0]   <= bus.rx_data;
              2'd1: asm_buf[15:8]  <= bus.rx_data;
              2'd2: asm_buf[23:16] <= bus.rx_data;
              default: begin
                // Fourth byte completes the word; the strobe appears next cycle.
                bus.im_wr_en <= 1'b1;
                bus.im_waddr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                bus.im_wdata <= {bus.rx_data, asm_buf};
                word_idx     <= word_idx + 16'd1;
                if (word_idx == word_count - 16'd1) begin
                  state        <= AFTER_IMAGE;
                  bus.rx_ready <= READY_AFTER;
                end
              end
            endcase
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          bus.rx_ready <= 1'b1;
          if (accept) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum) begin
              state <= DONE;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          if (reload) begin
            state        <= LEN0;
            done         <= 1'b0;
            cpu_reset    <= 1'b1;
            bus.rx_ready <= 1'b1;
            word_idx     <= '0;
            byte_cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end else begin
            // done lags entry into DONE by a cycle, so it never overlaps the last write.
            bus.rx_ready <= 1'b0;
            done         <= 1'b1;
            cpu_reset    <= 1'b0;
          end
        end
        default: begin
          state        <= ERR;
          bus.rx_ready <= 1'b0;
          error        <= 1'b1;
          cpu_reset    <= 1'b1;
        end
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept && (state == LEN0 || state == LEN1 || state == DATA)) begin
        csum <= csum ^ bus.rx_data;
      end
`endif
    end
  end
endmodule
